// File: rtl/vga_pkg.sv
// Shared geometry constants and the default-width row attribute record
// for the glyph serializer and its font-fetch side.
package vga_pkg;

   localparam int VGA_GLYPH_W = 8;
   localparam int VGA_COLOR_W = 4;
   localparam int VGA_REP_W   = 2;

   typedef struct packed {
      logic [VGA_COLOR_W-1:0] fg;
      logic [VGA_COLOR_W-1:0] bg;
      logic                   inv;
      logic [VGA_REP_W-1:0]   rep;
   } vga_attr_t;

endpackage

// File: rtl/vga_glyph_shreg.sv
// W-bit glyph row shifter with per-row bit replication and selectable bit order.
module vga_glyph_shreg
   import vga_pkg::*;
#(
   parameter int W         = VGA_GLYPH_W,
   parameter int REP_W     = VGA_REP_W,
   parameter int MSB_FIRST = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [W-1:0]     i_data,
   input  logic [REP_W-1:0] i_rep,
   output logic             o_act,
   output logic             o_bit,
   output logic             o_last
);

   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   logic             act_q, act_d;
   logic [W-1:0]     shreg_q, shreg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [W-1:0]     shreg_next;

   assign o_last = act_q & (bit_cnt_q == LAST_BIT) & (rep_cnt_q == rep_q);
   assign o_act  = act_q;
   assign o_bit  = (MSB_FIRST != 0) ? shreg_q[W-1] : shreg_q[0];

   // Shift toward the output end, zero fill behind.
   assign shreg_next = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

   always_comb begin
      act_d     = act_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      rep_cnt_d = rep_cnt_q;
      rep_d     = rep_q;
      if (i_clr) begin
         act_d     = 1'b0;
         bit_cnt_d = '0;
         rep_cnt_d = '0;
      end else if (i_en) begin
         if (i_load) begin
            act_d     = 1'b1;
            shreg_d   = i_data;
            rep_d     = i_rep;
            bit_cnt_d = '0;
            rep_cnt_d = '0;
         end else if (o_last) begin
            act_d     = 1'b0;
            bit_cnt_d = '0;
            rep_cnt_d = '0;
         end else if (act_q) begin
            if (rep_cnt_q != rep_q) begin
               rep_cnt_d = rep_cnt_q + REP_W'(1);
            end else begin
               rep_cnt_d = '0;
               shreg_d   = shreg_next;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         act_q     <= 1'b0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         rep_cnt_q <= '0;
         rep_q     <= '0;
      end else begin
         act_q     <= act_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         rep_cnt_q <= rep_cnt_d;
         rep_q     <= rep_d;
      end
   end

endmodule

// File: rtl/vga_glyph_serializer.sv
// Glyph row serializer: one-deep holding buffer in front of the shifter,
// per-row colour attributes and cursor invert, underrun flag at row end.
module vga_glyph_serializer
   import vga_pkg::*;
#(
   parameter int W         = VGA_GLYPH_W,
   parameter int REP_W     = VGA_REP_W,
   parameter int MSB_FIRST = 1,
   parameter int COLOR_W   = VGA_COLOR_W
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_clr,
   input  logic               i_load,
   input  logic [W-1:0]       i_data,
   input  logic [COLOR_W-1:0] i_fg,
   input  logic [COLOR_W-1:0] i_bg,
   input  logic               i_inv,
   input  logic [REP_W-1:0]   i_rep,
   output logic               o_ready,
   output logic               o_valid,
   output logic               o_pix,
   output logic [COLOR_W-1:0] o_color,
   output logic               o_underrun
);

   typedef struct packed {
      logic [COLOR_W-1:0] fg;
      logic [COLOR_W-1:0] bg;
      logic               inv;
      logic [REP_W-1:0]   rep;
   } attr_t;

   logic               hold_full_q, hold_full_d;
   logic [W-1:0]       hold_data_q, hold_data_d;
   attr_t              hold_attr_q, hold_attr_d;
   logic [COLOR_W-1:0] sh_fg_q, sh_fg_d;
   logic [COLOR_W-1:0] sh_bg_q, sh_bg_d;
   logic               sh_inv_q, sh_inv_d;
   logic               underrun_q, underrun_d;

   logic sh_act, sh_bit, sh_last;
   logic xfer, load_acc, act_vis;

   assign o_ready  = i_en & ~hold_full_q;
   assign load_acc = i_load & o_ready;
   // Load needs an empty buffer and transfer a full one, so they never coincide.
   assign xfer     = i_en & ~i_clr & hold_full_q & (~sh_act | sh_last);

   always_comb begin
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      hold_attr_d = hold_attr_q;
      sh_fg_d     = sh_fg_q;
      sh_bg_d     = sh_bg_q;
      sh_inv_d    = sh_inv_q;
      underrun_d  = underrun_q;
      if (i_clr) begin
         hold_full_d = 1'b0;
         underrun_d  = 1'b0;
      end else if (i_en) begin
         underrun_d = sh_last & ~hold_full_q;
         if (xfer) begin
            hold_full_d = 1'b0;
            sh_fg_d     = hold_attr_q.fg;
            sh_bg_d     = hold_attr_q.bg;
            sh_inv_d    = hold_attr_q.inv;
         end else if (load_acc) begin
            hold_full_d     = 1'b1;
            hold_data_d     = i_data;
            hold_attr_d.fg  = i_fg;
            hold_attr_d.bg  = i_bg;
            hold_attr_d.inv = i_inv;
            hold_attr_d.rep = i_rep;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         hold_attr_q <= '0;
         sh_fg_q     <= '0;
         sh_bg_q     <= '0;
         sh_inv_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         hold_attr_q <= hold_attr_d;
         sh_fg_q     <= sh_fg_d;
         sh_bg_q     <= sh_bg_d;
         sh_inv_q    <= sh_inv_d;
         underrun_q  <= underrun_d;
      end
   end

   vga_glyph_shreg #(
      .W         (W),
      .REP_W     (REP_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_clr   (i_clr),
      .i_load  (xfer),
      .i_data  (hold_data_q),
      .i_rep   (hold_attr_q.rep),
      .o_act   (sh_act),
      .o_bit   (sh_bit),
      .o_last  (sh_last)
   );

   assign act_vis    = i_en & sh_act;
   assign o_valid    = act_vis;
   assign o_pix      = act_vis & (sh_bit ^ sh_inv_q);
   assign o_color    = act_vis ? (o_pix ? sh_fg_q : sh_bg_q) : '0;
   assign o_underrun = underrun_q;

endmodule

// File: tb/tb_vga_glyph_serializer.sv
// Directed bench: an MSB-first and an LSB-first serializer share one stimulus stream.
module tb_vga_glyph_serializer;
   import vga_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, en, clr, load, inv;
   logic [7:0] data;
   logic [3:0] fg, bg;
   logic [1:0] rep;

   logic       r_m, v_m, p_m, u_m;
   logic [3:0] c_m;
   logic       r_l, v_l, p_l, u_l;
   logic [3:0] c_l;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_glyph_serializer #(.W(8), .REP_W(2), .MSB_FIRST(1), .COLOR_W(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_load(load),
      .i_data(data), .i_fg(fg), .i_bg(bg), .i_inv(inv), .i_rep(rep),
      .o_ready(r_m), .o_valid(v_m), .o_pix(p_m), .o_color(c_m), .o_underrun(u_m)
   );

   vga_glyph_serializer #(.W(8), .REP_W(2), .MSB_FIRST(0), .COLOR_W(4)) dut_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_load(load),
      .i_data(data), .i_fg(fg), .i_bg(bg), .i_inv(inv), .i_rep(rep),
      .o_ready(r_l), .o_valid(v_l), .o_pix(p_l), .o_color(c_l), .o_underrun(u_l)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_row(input logic [7:0] d, input vga_attr_t a);
      load = 1'b1;
      data = d;
      fg   = a.fg;
      bg   = a.bg;
      inv  = a.inv;
      rep  = a.rep;
      tick();
      load = 1'b0;
   endtask

   // Walk the active row from the current cycle; expected pixels are exp_bits
   // with the first pixel in bit exp_n-1.
   task automatic collect(input bit lsb, input int exp_n, input logic [31:0] exp_bits,
                          input logic [3:0] efg, input logic [3:0] ebg);
      int n;
      logic e, v, p, u;
      logic [3:0] c;
      n = 0;
      for (int k = 0; k < exp_n + 4; k++) begin
         v = lsb ? v_l : v_m;
         p = lsb ? p_l : p_m;
         c = lsb ? c_l : c_m;
         if (!v) break;
         e = (k < exp_n) ? exp_bits[exp_n-1-k] : 1'b0;
         chk("pix", {31'd0, p}, {31'd0, e});
         chk("color", {28'd0, c}, {28'd0, (e ? efg : ebg)});
         n++;
         tick();
      end
      u = lsb ? u_l : u_m;
      chk("row_len", n, exp_n);
      chk("underrun", {31'd0, u}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0; inv = 1'b0;
      data = '0; fg = '0; bg = '0; rep = '0;
      #1;
      chk("rst_ready", {31'd0, r_m}, 32'd1);
      chk("rst_valid", {31'd0, v_m}, 32'd0);
      chk("rst_pix", {31'd0, p_m}, 32'd0);
      chk("rst_color", {28'd0, c_m}, 32'd0);
      chk("rst_under", {31'd0, u_m}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // single row, rep 0
      put_row(8'hA5, '{fg: 4'hF, bg: 4'h1, inv: 1'b0, rep: 2'd0});
      chk("t1_ready_loaded", {31'd0, r_m}, 32'd0);
      chk("t1_valid_loaded", {31'd0, v_m}, 32'd0);
      tick();
      collect(1'b0, 8, 32'hA5, 4'hF, 4'h1);
      tick();
      chk("t1_under_drop", {31'd0, u_m}, 32'd0);

      // back-to-back rows
      put_row(8'hFF, '{fg: 4'hC, bg: 4'h3, inv: 1'b0, rep: 2'd0});
      chk("t2_ready_lo", {31'd0, r_m}, 32'd0);
      tick();
      chk("t2_ready_hi", {31'd0, r_m}, 32'd1);
      chk("t2_first_pix", {31'd0, p_m}, 32'd1);
      put_row(8'h00, '{fg: 4'hC, bg: 4'h3, inv: 1'b0, rep: 2'd0});
      chk("t2_ready_full", {31'd0, r_m}, 32'd0);
      collect(1'b0, 15, 32'h7F00, 4'hC, 4'h3);
      tick();

      // replication and invert, attributes frozen at load
      put_row(8'h81, '{fg: 4'hA, bg: 4'h5, inv: 1'b1, rep: 2'd1});
      rep = 2'd3; inv = 1'b0; fg = 4'h0; bg = 4'h0;
      tick();
      collect(1'b0, 16, 32'h3FFC, 4'hA, 4'h5);
      tick();

      // LSB-first build
      put_row(8'h01, '{fg: 4'h7, bg: 4'h2, inv: 1'b0, rep: 2'd0});
      tick();
      collect(1'b1, 8, 32'h80, 4'h7, 4'h2);
      tick();

      // enable stall mid-row with an ignored load
      put_row(8'hA5, '{fg: 4'h9, bg: 4'h4, inv: 1'b0, rep: 2'd0});
      tick();
      chk("t5_p0", {31'd0, p_m}, 32'd1);
      tick();
      chk("t5_p1", {31'd0, p_m}, 32'd0);
      chk("t5_v1", {31'd0, v_m}, 32'd1);
      tick();
      en = 1'b0; load = 1'b1; data = 8'hFF;
      #1;
      chk("t5_stall_valid", {31'd0, v_m}, 32'd0);
      chk("t5_stall_pix", {31'd0, p_m}, 32'd0);
      chk("t5_stall_color", {28'd0, c_m}, 32'd0);
      chk("t5_stall_ready", {31'd0, r_m}, 32'd0);
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("t5_stall_hold", {31'd0, v_m}, 32'd0);
      end
      en = 1'b1; load = 1'b0;
      #1;
      collect(1'b0, 6, 32'h25, 4'h9, 4'h4);
      tick();
      chk("t5_ready_after", {31'd0, r_m}, 32'd1);

      // flush with holding full
      put_row(8'hA5, '{fg: 4'h6, bg: 4'h8, inv: 1'b0, rep: 2'd0});
      tick();
      put_row(8'hFF, '{fg: 4'h6, bg: 4'h8, inv: 1'b0, rep: 2'd0});
      chk("t6_full", {31'd0, r_m}, 32'd0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t6_clr_valid", {31'd0, v_m}, 32'd0);
      chk("t6_clr_ready", {31'd0, r_m}, 32'd1);
      chk("t6_clr_under", {31'd0, u_m}, 32'd0);
      chk("t6_clr_lsb", {31'd0, v_l}, 32'd0);
      tick();
      chk("t6_clr_valid2", {31'd0, v_m}, 32'd0);
      chk("t6_clr_under2", {31'd0, u_m}, 32'd0);

      // asynchronous reset mid-row
      put_row(8'hFF, '{fg: 4'hE, bg: 4'hE, inv: 1'b0, rep: 2'd0});
      tick();
      tick();
      chk("t7_pre_valid", {31'd0, v_m}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_valid", {31'd0, v_m}, 32'd0);
      chk("t7_rst_pix", {31'd0, p_m}, 32'd0);
      chk("t7_rst_color", {28'd0, c_m}, 32'd0);
      chk("t7_rst_ready", {31'd0, r_m}, 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t7_post_valid", {31'd0, v_m}, 32'd0);
      chk("t7_post_under", {31'd0, u_m}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_glyph_serializer.md
Name: vga_glyph_serializer

Overview:
- Parametrised successor of the team's 8-bit pixel shift register.
- Serialises W-bit glyph rows into a pixel stream with:
  - a one-deep holding buffer, for gapless back-to-back rows;
  - per-row horizontal pixel replication;
  - selectable bit order;
  - per-row fg/bg colour attributes and cursor invert.
- Sits between the font-ROM fetch logic and the DAC/colour output stage of the text controller.

Parameters:
- W, 8, glyph row width in bits (>=2).
- REP_W, 2, width of the replication factor; each bit is held i_rep+1 clocks (1..2^REP_W).
- MSB_FIRST, 1, 1 = shift out bit W-1 first; 0 = bit 0 first.
- COLOR_W, 4, width of the colour index.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  clock enable / chip select; low freezes all state.
- i_clr  in  1  synchronous flush of both stages (line end).
- i_load  in  1  row-valid strobe; accepted only when o_ready=1 and i_en=1.
- i_data  in  W  glyph row bits.
- i_fg  in  COLOR_W  foreground index for this row.
- i_bg  in  COLOR_W  background index for this row.
- i_inv  in  1  invert pixels of this row (cursor).
- i_rep  in  REP_W  replication factor minus 1 for this row.
- o_ready  out  1  holding buffer empty.
- o_valid  out  1  shifter is outputting an active pixel.
- o_pix  out  1  current glyph bit after invert.
- o_color  out  COLOR_W  o_pix ? fg : bg.
- o_underrun  out  1  one-cycle pulse: row ended with no successor.

Behaviour:
- Reset (async, i_rst_n=0):
  - holding empty, shifter idle, counters 0.
  - o_ready=1, o_valid=0, o_pix=0, o_color=0, o_underrun=0.
- State:
  - holding: hold_full, data, fg, bg, inv, rep.
  - shifter: sh_act, shreg, bit_cnt (0..W-1), rep_cnt, latched attributes.
- Priority per edge: reset > i_clr > i_en=0 > normal.
- i_clr=1: hold_full=0 and sh_act=0 at the next edge; counters to 0; no underrun pulse.
- i_en=0:
  - all registers hold.
  - o_ready, o_valid, o_pix and o_color forced to 0.
  - loads are ignored.
- o_ready = i_en & !hold_full; it is registered-state based, with no combinational path from i_load.
- Load: i_load & o_ready at edge k writes the holding stage (hold_full=1).
- Transfer: at an edge where hold_full=1 and the shifter is free, copy holding into the shifter, set sh_act=1, clear hold_full, and zero bit_cnt and rep_cnt. The shifter is free when:
  - sh_act=0, or
  - it is on the last slice (bit_cnt=W-1 and rep_cnt=rep).
- Latency: row loaded at edge k into an idle block gives o_valid=1 from edge k+1 for exactly W*(rep+1) cycles.
- Back-to-back rows: when the holding stage is full at the last slice, the next row starts on the following cycle with zero bubble.
- Shift (sh_act=1, i_en=1):
  - if rep_cnt<rep: rep_cnt++.
  - else: rep_cnt=0 and shreg shifts one position toward the output end (zero fill); bit_cnt++.
- Output bit:
  - o_pix = (MSB_FIRST ? shreg[W-1] : shreg[0]) ^ inv.
  - o_color = o_pix ? fg : bg.
  - All outputs are 0 when sh_act=0.
- End of row:
  - last slice with hold_full=0: sh_act=0 at the next edge, and o_underrun=1 for that one cycle.
  - last slice with i_clr=1: no pulse.
- Simultaneous load and transfer cannot occur, because o_ready=0 whenever hold_full=1.
- A row's i_rep, fg, bg and inv are frozen at load; changing the inputs later has no effect.
- Reset mid-row: immediate return to the reset state; no partial pixels afterwards.

Decomposition:
- Shared package vga_pkg:
  - COLOR_W default constant.
  - Glyph width constant.
  - Attribute struct {fg, bg, inv, rep} for the holding and shifter stages.
- One natural sub-module: vga_glyph_shreg, the W-bit parametrised shifter with load, bit order and replication counter. The top level holds the holding buffer, handshake and colour mux.

Test Plan:
- Reset, then one row 8'hA5, fg=4'hF, bg=4'h1, rep=0, MSB_FIRST → o_valid high for 8 cycles; o_pix=1,0,1,0,0,1,0,1; o_color=F,1,F,1,1,F,1,F; o_underrun pulse on cycle 9.
- Rows 8'hFF then 8'h00 loaded while the first is shifting → 16 contiguous valid cycles with no bubble; o_ready low from the first load until the transfer.
- rep=1, row 8'h81, inv=1 → 16 valid cycles; o_pix=0,0,1,1,…,1,1,0,0.
- MSB_FIRST=0 build, row 8'h01 → first pixel 1, then seven 0s.
- Drop i_en for 3 cycles mid-row → outputs 0 during the stall; the row resumes at the same bit, total valid cycles unchanged; a load during the stall is ignored.
- Assert i_clr mid-row with holding full, then i_rst_n low mid-row → both stages empty, o_ready=1 next cycle, no o_underrun; reset clears all outputs asynchronously.
